// File: rtl/rr_mux_arb_if.sv
// Handshake bundle for rr_mux_arb: N producer channels in, one registered link out.
// Valid/ready rule on every port: a word moves on a rising edge where valid and ready are both high; valid never waits on ready, and data is held stable while valid is high and ready is low.
interface rr_mux_arb_if #(
  parameter int N = 6,
  parameter int W = 64
);
  localparam int SW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           fixed_prio;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;

  modport master (
    output in_valid, in_data, fixed_prio, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, fixed_prio, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_mux_arb.sv
// N-input, W-bit arbitrating mux: round-robin or fixed-priority grant into a single
// registered output stage; rr_ptr is exposed on dbg_rr_ptr for observation.
module rr_mux_arb #(
  parameter  int N  = 6,
  parameter  int W  = 64,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  rr_mux_arb_if.slave   bus,
  output logic [SW-1:0] dbg_rr_ptr
);

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] grant;
  logic [SW-1:0] next_ptr;
  logic [W-1:0]  grant_data;
  logic          hit;
  logic          any_valid;
  logic          load;
  logic [N-1:0]  ready_vec;

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_sel_q;

  assign any_valid = |bus.in_valid;
  assign load      = !out_valid_q || bus.out_ready;

  // Cyclic search as two linear passes: indices >= rr_ptr first, then the wrapped
  // part below rr_ptr. Fixed priority simply opens the first pass to every index.
  always_comb begin
    hit        = 1'b0;
    grant      = '0;
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (!hit && bus.in_valid[i] && (bus.fixed_prio || SW'(i) >= rr_ptr)) begin
        hit        = 1'b1;
        grant      = SW'(i);
        grant_data = bus.in_data[i*W +: W];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!hit && !bus.fixed_prio && bus.in_valid[i] && SW'(i) < rr_ptr) begin
        hit        = 1'b1;
        grant      = SW'(i);
        grant_data = bus.in_data[i*W +: W];
      end
    end
  end

  assign next_ptr = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < N; i++) begin
      ready_vec[i] = (grant == SW'(i));
    end
    bus.in_ready = (!reset && load && any_valid) ? ready_vec : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      if (any_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_sel_q   <= grant;
        if (!bus.fixed_prio) begin
          rr_ptr <= next_ptr;
        end
      end else begin
        // Drain: drop valid but keep the last word visible on the data lines.
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign dbg_rr_ptr    = rr_ptr;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb with N=6, W=8; channel i always presents 0x10+i. Directed phases
// push expected {sel,data} words; a negedge monitor pops them as the DUT hands words off.
module tb_rr_mux_arb;
  localparam int N  = 6;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk;
  logic          reset;
  logic [SW-1:0] rr_ptr;

  rr_mux_arb_if #(.N(N), .W(W)) bus ();

  rr_mux_arb #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .dbg_rr_ptr (rr_ptr)
  );

  int tests = 0;
  int fails = 0;
  logic [SW+W-1:0] exp_q[$];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [SW+W-1:0] exp_word(input int ch);
    exp_word = {SW'(ch), W'(8'h10 + ch)};
  endfunction

  task automatic push(input int ch);
    exp_q.push_back(exp_word(ch));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {21'd0, bus.out_sel, bus.out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [SW+W-1:0] e;
        e = exp_q.pop_front();
        check("word_sel", 32'(bus.out_sel), 32'(e[SW+W-1:W]));
        check("word_data", 32'(bus.out_data), 32'(e[W-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0] onehot;
    reset          = 1'b0;
    bus.in_valid   = '1;
    bus.out_ready  = 1'b1;
    bus.fixed_prio = 1'b0;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'(8'h10 + i);

    // Reset asserted between clock edges, all channels valid.
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_sel", 32'(bus.out_sel), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_rr_ptr", 32'(rr_ptr), 0);
    tick();
    tick();
    reset = 1'b0;

    // Round-robin rotation: 0..5,0,1,2, one word per cycle.
    for (int k = 0; k < 9; k++) begin
      push(k % N);
      @(negedge clk);
      onehot = N'(1) << (k % N);
      check("rr_in_ready", 32'(bus.in_ready), 32'(onehot));
      tick();
    end

    // Backpressure with 0x12 held.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_out_data", 32'(bus.out_data), 32'h12);
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_rr_ptr", 32'(rr_ptr), 3);
      tick();
    end
    bus.out_ready = 1'b1;
    push(3);
    @(negedge clk);
    check("bp_release_ready", 32'(bus.in_ready), 32'h08);
    tick();

    // Pointer wrap and skip: last grant 4, then only channels 1 and 5.
    push(4);
    tick();
    bus.in_valid = 6'b100010;
    push(5);
    push(1);
    push(5);
    tick();
    tick();
    tick();
    check("wrap_rr_ptr", 32'(rr_ptr), 0);

    // Fixed priority: set rr_ptr to 3 via a channel-2 grant first.
    bus.in_valid = 6'b000100;
    push(2);
    tick();
    bus.fixed_prio = 1'b1;
    bus.in_valid   = 6'b001100;
    for (int k = 0; k < 3; k++) begin
      push(2);
      @(negedge clk);
      check("fp_in_ready", 32'(bus.in_ready), 32'h04);
      check("fp_rr_ptr", 32'(rr_ptr), 3);
      tick();
    end
    bus.fixed_prio = 1'b0;
    push(3);
    @(negedge clk);
    check("fp_off_in_ready", 32'(bus.in_ready), 32'h08);
    tick();

    // Idle drain: one word from channel 0, then nothing.
    bus.in_valid = 6'b000001;
    push(0);
    tick();
    bus.in_valid = '0;
    @(negedge clk);
    check("drain_valid_hi", 32'(bus.out_valid), 1);
    tick();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("drain_valid_lo", 32'(bus.out_valid), 0);
      check("drain_data_hold", 32'(bus.out_data), 32'h10);
      check("drain_sel_hold", 32'(bus.out_sel), 0);
      tick();
    end

    // Reset mid-transfer discards a held word without a clock edge.
    bus.in_valid  = 6'b010000;
    bus.out_ready = 1'b0;
    tick();
    check("hold_valid", 32'(bus.out_valid), 1);
    check("hold_data", 32'(bus.out_data), 32'h14);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 0);
    check("async_out_data", 32'(bus.out_data), 0);
    check("async_out_sel", 32'(bus.out_sel), 0);
    check("async_in_ready", 32'(bus.in_ready), 0);
    check("async_rr_ptr", 32'(rr_ptr), 0);
    bus.in_valid = '0;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("idle_out_valid", 32'(bus.out_valid), 0);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
